// File: rtl/mioc_pkg.sv
// Shared definitions for the memory/IO bus controller.
//   state_t     : controller state encoding (IDLE/BUSY/DONE)
//   RAM_*/IO_*  : default inclusive address windows for slave 0 (RAM) and slave 1 (IO)
//   clog2()     : width helper for selects and the timeout counter (minimum 1)
package mioc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] RAM_LIMIT = 32'h0000_0FFF;
  localparam logic [31:0] IO_BASE   = 32'h0000_1000;
  localparam logic [31:0] IO_LIMIT  = 32'h0000_1027;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mioc_addr_decode.sv
// Combinational address decoder.
//   addr : byte address to decode
//   hit  : address falls inside at least one slave window
//   sel  : index of the matching slave; lowest index wins on overlap
module mioc_addr_decode
  import mioc_pkg::*;
#(
  parameter int unsigned N_SLV = 2,
  parameter int unsigned AW    = 32,
  parameter logic [N_SLV*AW-1:0] REGION_BASE  = {IO_BASE, RAM_BASE},
  parameter logic [N_SLV*AW-1:0] REGION_LIMIT = {IO_LIMIT, RAM_LIMIT},
  localparam int unsigned SW = clog2(N_SLV)
) (
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [SW-1:0] sel
);

  // Scan from the highest index down so the lowest matching index is written last.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int unsigned i = N_SLV; i > 0; i--) begin
      if (addr >= REGION_BASE[(i-1)*AW +: AW] && addr <= REGION_LIMIT[(i-1)*AW +: AW]) begin
        hit = 1'b1;
        sel = SW'(i - 1);
      end
    end
  end

endmodule

// File: rtl/mioc_bus_ctrl.sv
// Registered single-outstanding bus controller between the CPU memory stage
// and N_SLV address-mapped slaves.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   memCe/memWr         : CPU request valid / write strobe
//   memAddr/wtData      : CPU address / write data
//   rdData/memReady/memErr : completion data, one-cycle done pulse, error flag
//   slvCe/slvWe         : one-hot slave select / write enable
//   slvAddr/slvWtData   : latched address / write data toward the slave
//   slvRdData/slvAck    : per-slave read data slices / acknowledges
module mioc_bus_ctrl
  import mioc_pkg::*;
#(
  parameter int unsigned N_SLV = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter logic [N_SLV*AW-1:0] REGION_BASE  = {IO_BASE, RAM_BASE},
  parameter logic [N_SLV*AW-1:0] REGION_LIMIT = {IO_LIMIT, RAM_LIMIT},
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                memCe,
  input  logic                memWr,
  input  logic [AW-1:0]       memAddr,
  input  logic [DW-1:0]       wtData,
  output logic [DW-1:0]       rdData,
  output logic                memReady,
  output logic                memErr,
  output logic [N_SLV-1:0]    slvCe,
  output logic                slvWe,
  output logic [AW-1:0]       slvAddr,
  output logic [DW-1:0]       slvWtData,
  input  logic [N_SLV*DW-1:0] slvRdData,
  input  logic [N_SLV-1:0]    slvAck
);

  localparam int unsigned SW = clog2(N_SLV);
  localparam int unsigned CW = clog2(TIMEOUT);

  state_t          state, state_nx;
  logic            dec_hit;
  logic [SW-1:0]   dec_sel, sel_q, sel_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            sel_ack, timeout_hit;

  logic [DW-1:0]    rd_d, wdat_d;
  logic [AW-1:0]    addr_d;
  logic [N_SLV-1:0] ce_d;
  logic             ready_d, err_d, we_d;

  mioc_addr_decode #(
    .N_SLV       (N_SLV),
    .AW          (AW),
    .REGION_BASE (REGION_BASE),
    .REGION_LIMIT(REGION_LIMIT)
  ) u_decode (
    .addr(memAddr),
    .hit (dec_hit),
    .sel (dec_sel)
  );

  assign sel_ack     = slvAck[sel_q];
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (memCe) state_nx = dec_hit ? BUSY : DONE;
      BUSY:    if (sel_ack || timeout_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Computes the next value of every registered output; unchanged fields hold.
  always_comb begin
    rd_d    = rdData;
    err_d   = memErr;
    ready_d = 1'b0;
    ce_d    = slvCe;
    we_d    = slvWe;
    addr_d  = slvAddr;
    wdat_d  = slvWtData;
    sel_d   = sel_q;
    cnt_d   = '0;
    case (state)
      IDLE: begin
        if (memCe) begin
          if (dec_hit) begin
            ce_d          = '0;
            ce_d[dec_sel] = 1'b1;
            we_d          = memWr;
            addr_d        = memAddr;
            wdat_d        = wtData;
            sel_d         = dec_sel;
          end else begin
            err_d   = 1'b1;
            rd_d    = '0;
            ready_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (sel_ack) begin
          rd_d    = slvWe ? '0 : slvRdData[sel_q*DW +: DW];
          err_d   = 1'b0;
          ce_d    = '0;
          ready_d = 1'b1;
        end else if (timeout_hit) begin
          rd_d    = '0;
          err_d   = 1'b1;
          ce_d    = '0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdData    <= '0;
      memReady  <= 1'b0;
      memErr    <= 1'b0;
      slvCe     <= '0;
      slvWe     <= 1'b0;
      slvAddr   <= '0;
      slvWtData <= '0;
      sel_q     <= '0;
      cnt       <= '0;
    end else begin
      rdData    <= rd_d;
      memReady  <= ready_d;
      memErr    <= err_d;
      slvCe     <= ce_d;
      slvWe     <= we_d;
      slvAddr   <= addr_d;
      slvWtData <= wdat_d;
      sel_q     <= sel_d;
      cnt       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mioc_bus_ctrl.sv
// Scoreboard bench for mioc_bus_ctrl: stimulus pushes expected completions,
// a negedge monitor pops and compares them when memReady pulses, and a
// slave model checks the slave-side bus during every BUSY cycle.
module tb_mioc_bus_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        memCe = 1'b0, memWr = 1'b0;
  logic [31:0] memAddr = '0, wtData = '0;
  logic [31:0] rdData;
  logic        memReady, memErr;
  logic [1:0]  slvCe;
  logic        slvWe;
  logic [31:0] slvAddr, slvWtData;
  logic [63:0] slvRdData = '0;
  logic [1:0]  slvAck = '0;

  mioc_bus_ctrl #(
    .N_SLV  (2),
    .AW     (32),
    .DW     (32),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .memCe    (memCe),
    .memWr    (memWr),
    .memAddr  (memAddr),
    .wtData   (wtData),
    .rdData   (rdData),
    .memReady (memReady),
    .memErr   (memErr),
    .slvCe    (slvCe),
    .slvWe    (slvWe),
    .slvAddr  (slvAddr),
    .slvWtData(slvWtData),
    .slvRdData(slvRdData),
    .slvAck   (slvAck)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_cnt = 0;

  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          due;
  } exp_t;
  exp_t sbq[$];

  logic [1:0]  exp_ce = '0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = '0, exp_wd = '0;
  int          ack_at = 0;
  logic [31:0] ack_val = '0;
  logic        stray = 1'b0;
  logic        chk_no_ce = 1'b0;
  int          bcnt = 0;

  // Slave model: acks in BUSY cycle ack_at (1-based, 0 = never) and checks the bus.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      slvAck    = 2'($urandom);
      slvRdData = {$urandom, $urandom};
      bcnt      = 0;
    end else if (slvCe == 2'b00) begin
      slvAck = '0;
      bcnt   = 0;
    end else begin
      bcnt = bcnt + 1;
      total++;
      if (slvCe !== exp_ce || slvWe !== exp_we || slvAddr !== exp_addr || slvWtData !== exp_wd) begin
        bad++;
        $display("FAIL slave_bus cyc=%0d: got ce=%b we=%b addr=%h wd=%h, want ce=%b we=%b addr=%h wd=%h",
                 cyc, slvCe, slvWe, slvAddr, slvWtData, exp_ce, exp_we, exp_addr, exp_wd);
      end
      if (ack_at > 0 && bcnt == ack_at) begin
        slvAck    = exp_ce;
        slvRdData = exp_ce[0] ? {~ack_val, ack_val} : {ack_val, ~ack_val};
      end else begin
        slvAck    = stray ? ~exp_ce : 2'b00;
        slvRdData = {$urandom, $urandom};
      end
    end
  end

  // Monitor: compares each completion pulse against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_no_ce) begin
        total++;
        if (slvCe !== 2'b00) begin
          bad++;
          $display("FAIL no_slvce cyc=%0d: got slvCe=%b, want 00", cyc, slvCe);
        end
      end
      if (memReady) begin
        rdy_cnt++;
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ready cyc=%0d: got memReady=1, want 0", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (rdData !== e.rd || memErr !== e.err || cyc != e.due) begin
            bad++;
            $display("FAIL completion cyc=%0d: got rd=%h err=%b, want rd=%h err=%b at cyc=%0d",
                     cyc, rdData, memErr, e.rd, e.err, e.due);
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input int at, input logic [31:0] av, input logic [1:0] ece,
                       input logic [31:0] erd, input logic eerr, input int lat,
                       input logic hold, output int start);
    exp_t e;
    bit   seen;
    @(posedge clk);
    #1;
    memAddr = a; memWr = w; wtData = wd; memCe = 1'b1;
    ack_at = at; ack_val = av;
    exp_ce = ece; exp_we = w; exp_addr = a; exp_wd = wd;
    chk_no_ce = (ece == 2'b00);
    start = cyc;
    e.rd = erd; e.err = eerr; e.due = cyc + lat;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) memCe = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < lat + 8 && !seen; n++) begin
      @(negedge clk);
      if (memReady) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL ready_timeout addr=%h: got no memReady, want one within %0d cycles", a, lat + 8);
      sbq.delete();
    end
  endtask

  initial begin
    int s0, s1, s2, dummy;
    #1 rst_n = 1'b0;

    // Held in reset with random inputs: every output must stay 0.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      memCe = 1'($urandom); memWr = 1'($urandom); memAddr = $urandom; wtData = $urandom;
      @(negedge clk);
      total++;
      if ({rdData, memReady, memErr, slvCe, slvWe, slvAddr, slvWtData} !== '0) begin
        bad++;
        $display("FAIL reset_outputs: got rd=%h rdy=%b err=%b ce=%b we=%b addr=%h wd=%h, want all 0",
                 rdData, memReady, memErr, slvCe, slvWe, slvAddr, slvWtData);
      end
    end
    @(posedge clk);
    #1;
    memCe = 1'b0;
    rst_n = 1'b1;

    //    addr          wr  wdata         ack val           ce     exp rd        err lat
    issue(32'h0000_0010, 0, 32'h0,        1, 32'hDEAD_BEEF, 2'b01, 32'hDEAD_BEEF, 0, 2,      0, dummy);
    issue(32'h0000_1028, 0, 32'h0,        0, 32'h0,         2'b00, 32'h0,         1, 1,      0, dummy);
    issue(32'h0000_1000, 0, 32'h0,        1, 32'hA5A5_0001, 2'b10, 32'hA5A5_0001, 0, 2,      0, dummy);
    issue(32'hFFFF_FFFC, 0, 32'h0,        0, 32'h0,         2'b00, 32'h0,         1, 1,      0, dummy);
    issue(32'h0000_1024, 1, 32'h55,       3, 32'h1234_5678, 2'b10, 32'h0,         0, 4,      0, dummy);
    issue(32'h0000_0FFF, 0, 32'h0,        2, 32'h0BAD_F00D, 2'b01, 32'h0BAD_F00D, 0, 3,      0, dummy);
    stray = 1'b1;
    issue(32'h0000_0100, 0, 32'h0,        0, 32'h0,         2'b01, 32'h0,         1, TO + 1, 0, dummy);
    stray = 1'b0;
    issue(32'h0000_1027, 0, 32'h0,        1, 32'hC0FF_EE00, 2'b10, 32'hC0FF_EE00, 0, 2,      0, dummy);
    issue(32'h0000_0FFC, 1, 32'hCAFE,     1, 32'h0000_0077, 2'b01, 32'h0,         0, 2,      0, dummy);

    // Continuous memCe stream: one acceptance every 3 cycles with single-cycle acks.
    issue(32'h0000_0000, 0, 32'h0,        1, 32'h1111_0001, 2'b01, 32'h1111_0001, 0, 2,      1, s0);
    issue(32'h0000_1020, 0, 32'h0,        1, 32'h2222_0002, 2'b10, 32'h2222_0002, 0, 2,      1, s1);
    issue(32'h0000_0800, 0, 32'h0,        1, 32'h3333_0003, 2'b01, 32'h3333_0003, 0, 2,      1, s2);
    memCe = 1'b0;
    total++;
    if (s1 - s0 != 3 || s2 - s1 != 3) begin
      bad++;
      $display("FAIL stream_period: got %0d,%0d cycles, want 3,3", s1 - s0, s2 - s1);
    end

    // Reset in the middle of BUSY: slave select drops at once, no completion follows.
    @(posedge clk);
    #1;
    memAddr = 32'h0000_0020; memWr = 1'b0; memCe = 1'b1;
    ack_at = 0; exp_ce = 2'b01; exp_we = 1'b0; exp_addr = 32'h0000_0020; exp_wd = wtData;
    chk_no_ce = 1'b0;
    @(posedge clk);
    #1;
    memCe = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (slvCe !== 2'b01) begin
      bad++;
      $display("FAIL busy_before_reset: got slvCe=%b, want 01", slvCe);
    end
    #2;
    rst_n = 1'b0;
    rdy_cnt = 0;
    #1;
    total++;
    if (slvCe !== 2'b00 || memReady !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got slvCe=%b memReady=%b, want 00 0", slvCe, memReady);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (TO + 4) @(negedge clk);
    total++;
    if (rdy_cnt != 0) begin
      bad++;
      $display("FAIL reset_abort: got %0d memReady pulses, want 0", rdy_cnt);
    end

    issue(32'h0000_0044, 0, 32'h0,        1, 32'h600D_F00D, 2'b01, 32'h600D_F00D, 0, 2,      0, dummy);

    repeat (4) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mioc_bus_ctrl.md
Name: mioc_bus_ctrl

Overview:
- Parametrised, registered memory/IO bus controller between the CPU memory stage and N_SLV address-mapped slaves (RAM, IO, future peripherals).
- Decodes the address against per-slave base/limit windows and drives a single-outstanding request handshake to the selected slave.
- Waits for the slave acknowledge and returns read data with a one-cycle completion pulse.
- Reports unmapped addresses and slave timeouts as bus errors instead of leaving outputs undriven.

Parameters:
- N_SLV, 2, number of slave regions.
- AW, 32, address width.
- DW, 32, data width.
- REGION_BASE, {32'h0000_1000, 32'h0000_0000}, packed N_SLV*AW; slice i is the inclusive base of slave i.
- REGION_LIMIT, {32'h0000_1027, 32'h0000_0FFF}, packed N_SLV*AW; slice i is the inclusive limit of slave i.
- TIMEOUT, 16, BUSY cycles without ack before an error completion (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- memCe  in  1  CPU request valid; held until memReady.
- memWr  in  1  1=write, 0=read.
- memAddr  in  AW  byte address.
- wtData  in  DW  write data.
- rdData  out  DW  read data; valid while memReady=1.
- memReady  out  1  one-cycle completion pulse.
- memErr  out  1  error flag, qualified by memReady.
- slvCe  out  N_SLV  one-hot slave select.
- slvWe  out  1  write enable for the selected slave.
- slvAddr  out  AW  latched address, absolute.
- slvWtData  out  DW  latched write data.
- slvRdData  in  N_SLV*DW  per-slave read data; slice i belongs to slave i.
- slvAck  in  N_SLV  per-slave acknowledge.

Behaviour:
- All outputs are registered. Reset is asynchronous and active-low: all outputs go to 0, the state goes to IDLE and the timeout counter goes to 0. A reset mid-transaction aborts it with no completion pulse.
- Decode: slave i hits when REGION_BASE[i] <= memAddr <= REGION_LIMIT[i], compared unsigned. On overlapping windows the lowest index wins.
- States: IDLE, BUSY, DONE.
- IDLE, memCe=0: slvCe=0 and memReady=0.
- IDLE, memCe=1 with a hit:
  - latch memAddr, wtData, memWr and sel;
  - go to BUSY;
  - slvCe[sel]=1, slvWe=memWr and slvAddr/slvWtData are driven from the next cycle onward.
- IDLE, memCe=1 with no hit: go to DONE with memErr=1 and rdData=0. No slvCe is asserted.
- BUSY:
  - slvCe and slvWe are held stable.
  - Only slvAck[sel] is observed; acks from other slaves are ignored.
  - On slvAck[sel]=1: rdData takes slvRdData slice sel for a read, or 0 for a write. memErr=0. slvCe clears. Go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without an ack: memErr=1, rdData=0, slvCe clears, go to DONE.
  - The counter clears on leaving BUSY.
- DONE: memReady=1 for exactly this cycle, then return to IDLE. memCe is not sampled in DONE, so back-to-back requests cost one idle cycle.
- Latency, request at cycle 0 with ack in the first BUSY cycle:
  - BUSY in cycle 1 (slave sees slvCe);
  - memReady in cycle 2;
  - next request accepted in cycle 3.
- Unmapped-address errors have memReady in cycle 1.
- memCe dropping during BUSY does not abort; the transaction completes normally.
- rdData and memErr hold their last values after DONE until the next completion. memReady is the only pulse.
- A single outstanding transaction; there is no pipelining.

Decomposition:
- mioc_pkg holds: the state enum (IDLE/BUSY/DONE), the default region base/limit constants for RAM (0x0000–0x0FFF) and IO (0x1000–0x1027), and the timeout-counter width function clog2(TIMEOUT).
- One sub-module, mioc_addr_decode: combinational and parametrised on N_SLV/AW/REGION_BASE/REGION_LIMIT. Outputs are hit and sel[clog2(N_SLV)-1:0], resolved by priority encoder.
- The FSM, latches and timeout counter live in mioc_bus_ctrl.

Test Plan:
- Reset: hold rst_n=0 and drive random inputs -> all outputs 0. Assert rst_n=0 mid-BUSY -> slvCe drops immediately and no memReady follows.
- RAM read: memAddr=0x0000_0010, memWr=0, slave0 acks in its first BUSY cycle with 0xDEAD_BEEF -> slvCe=2'b01 in cycle 1; memReady=1, rdData=0xDEAD_BEEF, memErr=0 in cycle 2.
- IO write with wait states: memAddr=0x0000_1024, wtData=0x55, slave1 acks after 3 cycles -> slvCe=2'b10, slvWe=1, slvWtData=0x55 held stable for 3 cycles; memReady=1, rdData=0, memErr=0.
- Unmapped address: memAddr=0x0000_1028, then 0xFFFF_FFFC -> memReady=1 and memErr=1 one cycle after each request; slvCe stays 0.
- Timeout: read 0x0000_0100 with slave0 never acking -> memErr=1, memReady pulses exactly TIMEOUT cycles after entering BUSY, slvCe clears. A stray slvAck[1] during BUSY is ignored.
- Boundaries/back-to-back: addresses 0x0FFF, 0x1000 and 0x1027 each select the correct slave. A continuous memCe stream is accepted every (BUSY cycles + 2) cycles. memCe deasserted mid-BUSY still completes the transaction.
